// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared memory-port handshake between the sequencer and memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ifetch;
  logic mem_ready;
  modport master (output mem_req, mem_we, mem_ifetch, input mem_ready);
  modport slave (input mem_req, mem_we, mem_ifetch, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with a watchdog on the shared memory port
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TW = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master mem,
  input  logic [6:0]       opcode,
  input  logic             s_mem_read,
  input  logic             s_mem_write,
  input  logic             s_reg_write,
  input  logic             s_branch,
  input  logic [1:0]       s_pc_sel,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic             halt,
  output logic [1:0]       err,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  logic [2:0] nxt;
  logic [TW-1:0] wd;
  logic rst_q, go, legal, sys, ill, expire;
  // strobes stay quiet during the reset cycle and the one right after it
  assign go = !rst && !rst_q;
  assign legal = opcode[6:2] inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                     5'b11011, 5'b11001, 5'b01101, 5'b00101};
  assign sys = opcode[6:2] == 5'b11100;
  assign ill = opcode[1:0] != 2'b11 || !(legal || sys);
  // ready arriving in the last allowed cycle completes the access rather than trapping
  assign expire = mem.mem_req && !mem.mem_ready && wd == WD_LAST;
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? FETCH : nxt;
  end
  // next-state logic; only FETCH and MEM look at mem_ready
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = mem.mem_req && mem.mem_ready ? DECODE : expire ? HALT : FETCH;
      DECODE:  nxt = ill || sys ? HALT : EXEC;
      EXEC:    nxt = s_mem_read || s_mem_write ? MEM : WB;
      MEM:     nxt = mem.mem_req && mem.mem_ready ? WB : expire ? HALT : MEM;
      WB:      nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // output decode from registered state; ir_we/mdr_we additionally follow mem_ready
  always_comb begin
    mem.mem_req = go && (state == FETCH || state == MEM);
    mem.mem_ifetch = go && state == FETCH;
    mem.mem_we = go && state == MEM && s_mem_write;
    ir_we = go && state == FETCH && mem.mem_ready;
    mdr_we = go && state == MEM && s_mem_read && mem.mem_ready;
    pc_we = go && state == WB;
    reg_we = pc_we && s_reg_write;
    instr_retired = pc_we;
    pc_sel = !pc_we ? 2'b00 : s_branch ? {1'b0, branch_taken} : s_pc_sel;
    halt = state == HALT;
  end
  // watchdog, trap cause and retired-instruction counter
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wd <= '0;
      err <= 2'b00;
      retired_cnt <= '0;
    end else begin
      wd <= mem.mem_req && !mem.mem_ready ? wd + 1'b1 : '0;
      if (state == DECODE && ill) err <= 2'b01;
      else if (expire) err <= 2'b10;
      if (instr_retired) retired_cnt <= retired_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench driving instruction sequences through the sequencer
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam int NEVER = 1000;
  typedef struct {
    logic hlt;
    logic [1:0] err;
    logic [1:0] ps;
    int lat, nf, nd, nwe, nir, nmdr, npc, nrw;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode = '0;
  logic s_mem_read = 0, s_mem_write = 0, s_reg_write = 0, s_branch = 0, branch_taken = 0;
  logic [1:0] s_pc_sel = '0;
  logic ir_we, mdr_we, pc_we, reg_we, halt, instr_retired;
  logic [1:0] pc_sel, err;
  logic [31:0] retired_cnt;
  logic [2:0] st;
  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;
  logic [31:0] exp_cnt = '0;
  multicycle_ctrl_if mif();
  multicycle_ctrl #(.TIMEOUT(TO), .TW(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem(mif), .opcode(opcode),
    .s_mem_read(s_mem_read), .s_mem_write(s_mem_write), .s_reg_write(s_reg_write),
    .s_branch(s_branch), .s_pc_sel(s_pc_sel), .branch_taken(branch_taken),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .halt(halt), .err(err), .instr_retired(instr_retired), .retired_cnt(retired_cnt), .state(st)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    check("rst_mem_req", mif.mem_req, 0);
    check("rst_ir_we", ir_we, 0);
    check("rst_pc_we", pc_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", st, 0);
    check("rst_halt", halt, 0);
    check("rst_err", err, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_after_req", mif.mem_req, 0);
    exp_cnt = '0;
  endtask
  task automatic run(input logic [6:0] op, input logic mr, mw, rw, br, bt, input logic [1:0] ps,
                     input int wf, wm);
    exp_t e, g;
    logic legal, sys, ill, memop, started, done;
    int wc, cyc;
    legal = op[6:2] inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                            5'b11011, 5'b11001, 5'b01101, 5'b00101};
    sys = op[6:2] == 5'b11100;
    ill = op[1:0] != 2'b11 || !(legal || sys);
    memop = mr || mw;
    e = '{default: 0};
    e.nf = wf >= TO ? TO : wf + 1;
    e.nir = wf >= TO ? 0 : 1;
    if (wf >= TO) begin e.hlt = 1; e.err = 2'b10; end
    else if (ill) begin e.hlt = 1; e.err = 2'b01; end
    else if (sys) e.hlt = 1;
    else if (memop && wm >= TO) begin
      e.hlt = 1; e.err = 2'b10; e.nd = TO; e.nwe = mw ? TO : 0;
    end else begin
      e.nd = memop ? wm + 1 : 0;
      e.nwe = mw ? wm + 1 : 0;
      e.nmdr = mr ? 1 : 0;
      e.lat = memop ? 5 + wf + wm : 4 + wf;
      e.npc = 1;
      e.nrw = rw ? 1 : 0;
      e.ps = br ? {1'b0, bt} : ps;
      exp_cnt++;
    end
    e.cnt = exp_cnt;
    sb.push_back(e);
    opcode = op; s_mem_read = mr; s_mem_write = mw; s_reg_write = rw;
    s_branch = br; branch_taken = bt; s_pc_sel = ps;
    g = '{default: 0};
    wc = 0; cyc = 0; started = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!started && mif.mem_req && mif.mem_ifetch) started = 1;
      if (started) cyc++;
      if (st == 3'd5) begin
        g.hlt = 1;
        done = 1;
      end else begin
        mif.mem_ready = mif.mem_req ? (wc == (mif.mem_ifetch ? wf : wm)) : 1'b1;
        #1;
        if (mif.mem_req) wc = mif.mem_ready ? 0 : wc + 1;
        g.nf += int'(mif.mem_req && mif.mem_ifetch);
        g.nd += int'(mif.mem_req && !mif.mem_ifetch);
        g.nwe += int'(mif.mem_we);
        g.nir += int'(ir_we);
        g.nmdr += int'(mdr_we);
        g.npc += int'(pc_we);
        g.nrw += int'(reg_we);
        if (instr_retired) begin
          g.lat = cyc;
          g.ps = pc_sel;
          done = 1;
        end
      end
    end
    check("done", done, 1);
    e = sb.pop_front();
    check("halted", g.hlt, e.hlt);
    check("halt_out", halt, e.hlt);
    check("fetch_cycles", g.nf, e.nf);
    check("data_cycles", g.nd, e.nd);
    check("mem_we_cycles", g.nwe, e.nwe);
    check("ir_we_pulses", g.nir, e.nir);
    check("mdr_we_pulses", g.nmdr, e.nmdr);
    check("pc_we_pulses", g.npc, e.npc);
    check("reg_we_pulses", g.nrw, e.nrw);
    if (e.hlt) begin
      check("err", err, e.err);
      check("cnt_at_halt", retired_cnt, e.cnt);
      repeat (3) @(negedge clk);
      #1;
      check("halt_hold_state", st, 5);
      check("halt_hold_req", mif.mem_req, 0);
      check("halt_hold_pc_we", pc_we, 0);
    end else begin
      check("latency", g.lat, e.lat);
      check("pc_sel", g.ps, e.ps);
      @(posedge clk);
      #1;
      check("retired_cnt", retired_cnt, e.cnt);
    end
  endtask
  task automatic mid_mem_reset();
    int wc;
    wc = 0;
    opcode = 7'b0000011; s_mem_read = 1; s_mem_write = 0; s_reg_write = 1; s_branch = 0;
    for (int k = 0; k < 50 && wc < 2; k++) begin
      @(negedge clk);
      mif.mem_ready = !mif.mem_req || mif.mem_ifetch;
      #1;
      if (st == 3'd3) wc++;
    end
    @(negedge clk);
    check("mmr_in_mem", st, 3);
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    check("mmr_req_during", mif.mem_req, 0);
    check("mmr_mdr_we", mdr_we, 0);
    check("mmr_reg_we", reg_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mmr_state", st, 0);
    check("mmr_req_after", mif.mem_req, 0);
    check("mmr_cnt", retired_cnt, 0);
    exp_cnt = '0;
  endtask
  initial begin
    mif.mem_ready = 1'b0;
    do_reset();
    run(7'b0010011, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    run(7'b0000011, 1, 0, 1, 0, 0, 2'b00, 2, 3);
    run(7'b1100011, 0, 0, 0, 1, 1, 2'b01, 0, 0);
    run(7'b1100011, 0, 0, 0, 1, 0, 2'b01, 1, 0);
    run(7'b1101111, 0, 0, 1, 0, 0, 2'b10, 1, 0);
    run(7'b1100111, 0, 0, 1, 0, 1, 2'b11, 0, 0);
    run(7'b0110111, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    run(7'b0100011, 0, 1, 0, 0, 0, 2'b00, 0, TO - 1);
    run(7'b0100011, 0, 1, 0, 0, 0, 2'b00, 0, NEVER);
    do_reset();
    run(7'b0010011, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    run(7'b0000000, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    do_reset();
    run(7'b0010011, 0, 0, 1, 0, 0, 2'b00, 1, 0);
    run(7'b1110011, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_reset();
    run(7'b0010001, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    do_reset();
    run(7'b0010011, 0, 0, 1, 0, 0, 2'b00, NEVER, 0);
    do_reset();
    mid_mem_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
